fs_en_scheduler: RTL and testbench

Symbol-rate enable scheduler for the DVB-S2 modulator output path. Generates the one-cycle `fs_en` strobe on `sys_clk` from a fractional phase accumulator and paces it against the fill level of the symbol FIFO that `fs_en` drains. Sequences start-up priming, steady run, underflow recovery and drain-to-idle. Sits between the frame/symbol FIFO and the DAC-side logic that consumes one symbol per `fs_en`.

---
 rtl/fs_en_scheduler_if.sv | 31 +++
 rtl/fs_en_scheduler.sv | 139 +++++++++++++
 tb/tb_fs_en_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fs_en_scheduler_if.sv
// fs_en_scheduler_if: control, FIFO status and strobe/status bundle for the
// symbol-rate enable scheduler. The master side (controller, FIFO status)
// drives configuration and FIFO status. The slave side (scheduler) returns
// the strobe, the state and the statistics.
interface fs_en_scheduler_if #(
    parameter int ACC_WIDTH   = 32,
    parameter int LEVEL_WIDTH = 6
);
    logic                   enable;
    logic [ACC_WIDTH-1:0]   rate_word;
    logic                   cfg_load;
    logic [LEVEL_WIDTH-1:0] fifo_level;
    logic                   fifo_empty;
    logic                   clear_underflow;
    logic                   fs_en;
    logic [1:0]             state;
    logic                   busy;
    logic                   underflow;
    logic [31:0]            strobe_cnt;
    logic [15:0]            underflow_cnt;

    modport master (
        output enable, rate_word, cfg_load, fifo_level, fifo_empty, clear_underflow,
        input  fs_en, state, busy, underflow, strobe_cnt, underflow_cnt
    );

    modport slave (
        input  enable, rate_word, cfg_load, fifo_level, fifo_empty, clear_underflow,
        output fs_en, state, busy, underflow, strobe_cnt, underflow_cnt
    );
endinterface

// File: rtl/fs_en_scheduler.sv
// fs_en_scheduler: generates the one-cycle fs_en symbol strobe from the
// carry-out of a fractional phase accumulator. The strobe is paced against
// the symbol FIFO. The block sequences IDLE -> PRIME -> RUN -> DRAIN.
// An empty FIFO at a strobe instant suppresses the strobe, sets the sticky
// underflow flag and sends the block back to PRIME.
// Optional statistics counters are built when FS_EN_SCHEDULER_STATS_EN is
// defined. Otherwise strobe_cnt and underflow_cnt are tied to zero.
module fs_en_scheduler #(
    parameter int ACC_WIDTH   = 32,
    parameter int LEVEL_WIDTH = 6,
    parameter int PRIME_LEVEL = 16
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    fs_en_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [LEVEL_WIDTH-1:0] PRIME_THRESH = LEVEL_WIDTH'(PRIME_LEVEL);

    state_t               state_q, state_n;
    logic [ACC_WIDTH-1:0] acc_q, acc_n;
    logic [ACC_WIDTH-1:0] rate_q;
    logic                 fs_en_q, fs_en_n;
    logic                 busy_q;
    logic                 underflow_q, underflow_n;
    logic                 uf_event;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    // One extra bit keeps the accumulator carry. That carry is the only strobe source.
    assign sum   = {1'b0, acc_q} + {1'b0, rate_q};
    assign carry = sum[ACC_WIDTH];

    // Next-state, accumulator and strobe decisions for the sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        state_n  = state_q;
        acc_n    = acc_q;
        fs_en_n  = 1'b0;
        uf_event = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                acc_n = '0;
                if (bus.enable) state_n = ST_PRIME;
            end
            ST_PRIME: begin
                acc_n = '0;
                if (!bus.enable)                        state_n = ST_IDLE;
                else if (bus.fifo_level >= PRIME_THRESH) state_n = ST_RUN;
            end
            ST_RUN: begin
                if (carry && bus.fifo_empty) begin
                    // Strobe would read an empty FIFO: suppress it and re-prime.
                    uf_event = 1'b1;
                    acc_n    = '0;
                    state_n  = ST_PRIME;
                end else begin
                    acc_n   = sum[ACC_WIDTH-1:0];
                    fs_en_n = carry;
                    if (!bus.enable) state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.fifo_empty) begin
                    // Drain is complete. An empty FIFO here is expected, not an underflow.
                    acc_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    acc_n   = sum[ACC_WIDTH-1:0];
                    fs_en_n = carry;
                    if (bus.enable) state_n = ST_RUN;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Sticky flag: a new event in the same cycle beats the clear strobe.
        underflow_n = underflow_q;
        if (bus.clear_underflow) underflow_n = 1'b0;
        if (uf_event)            underflow_n = 1'b1;
    end

    // Sequencer state, accumulator and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            fs_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            state_q     <= state_n;
            acc_q       <= acc_n;
            fs_en_q     <= fs_en_n;
            busy_q      <= (state_n != ST_IDLE);
            underflow_q <= underflow_n;
        end
    end

    // Rate word latch. A rate change does not disturb the accumulator phase.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)            rate_q <= '0;
        else if (bus.cfg_load) rate_q <= bus.rate_word;
    end

    assign bus.fs_en     = fs_en_q;
    assign bus.state     = state_q;
    assign bus.busy      = busy_q;
    assign bus.underflow = underflow_q;

`ifdef FS_EN_SCHEDULER_STATS_EN
    logic [31:0] strobe_cnt_q;
    logic [15:0] underflow_cnt_q;

    // Statistics: the strobe count wraps and the underflow count saturates. Only reset clears them.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_cnt_q    <= '0;
            underflow_cnt_q <= '0;
        end else begin
            if (fs_en_n)                              strobe_cnt_q    <= strobe_cnt_q + 32'd1;
            if (uf_event && underflow_cnt_q != 16'hFFFF) underflow_cnt_q <= underflow_cnt_q + 16'd1;
        end
    end

    assign bus.strobe_cnt    = strobe_cnt_q;
    assign bus.underflow_cnt = underflow_cnt_q;
`else
    assign bus.strobe_cnt    = '0;
    assign bus.underflow_cnt = '0;
`endif
endmodule

// File: tb/tb_fs_en_scheduler.sv
// tb_fs_en_scheduler: directed stimulus against a behavioural model of the
// scheduler. The model uses wide integer phase arithmetic. A negedge compare
// process checks every cycle. Literal expectations pin strobe counts,
// latencies and state codes.
module tb_fs_en_scheduler;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    fs_en_scheduler_if bus ();

    fs_en_scheduler dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    localparam logic [31:0] RATE_HALF    = 32'h8000_0000;
    localparam logic [31:0] RATE_QUARTER = 32'h4000_0000;
    localparam logic [31:0] RATE_MAX     = 32'hFFFF_FFFF;
    localparam longint unsigned MOD      = 64'h1_0000_0000;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: state code, phase, rate, outputs, statistics.
    int              m_state;
    longint unsigned m_acc, m_rate, m_scnt;
    int              m_ucnt;
    bit              m_fs, m_uf;
    bit              chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_acc = 0; m_rate = 0; m_scnt = 0; m_ucnt = 0;
        m_fs = 1'b0; m_uf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees at that edge.
    task automatic model_step();
        longint unsigned s;
        bit cy, strobe, uf_ev;
        int nxt;
        s      = m_acc + m_rate;
        cy     = (s >= MOD);
        s      = s % MOD;
        strobe = 1'b0;
        uf_ev  = 1'b0;
        nxt    = m_state;
        case (m_state)
            0: begin m_acc = 0; if (bus.enable) nxt = 1; end
            1: begin
                m_acc = 0;
                if (!bus.enable) nxt = 0;
                else if (int'(bus.fifo_level) >= 16) nxt = 2;
            end
            2: begin
                if (cy && bus.fifo_empty) begin uf_ev = 1'b1; m_acc = 0; nxt = 1; end
                else begin m_acc = s; strobe = cy; if (!bus.enable) nxt = 3; end
            end
            default: begin
                if (bus.fifo_empty) begin m_acc = 0; nxt = 0; end
                else begin m_acc = s; strobe = cy; if (bus.enable) nxt = 2; end
            end
        endcase
        m_state = nxt;
        m_fs    = strobe;
        if (bus.clear_underflow) m_uf = 1'b0;
        if (uf_ev)               m_uf = 1'b1;
        if (bus.cfg_load)        m_rate = longint'(bus.rate_word);
        if (strobe)              m_scnt = (m_scnt + 1) % MOD;
        if (uf_ev && m_ucnt < 65535) m_ucnt++;
    endtask

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge sys_clk) begin
        if (chk_on) begin
            logic [63:0] exp_s, exp_u;
`ifdef FS_EN_SCHEDULER_STATS_EN
            exp_s = m_scnt;
            exp_u = 64'(m_ucnt);
`else
            exp_s = 64'd0;
            exp_u = 64'd0;
`endif
            check("cyc_fs_en",     bus.fs_en,     m_fs);
            check("cyc_state",     bus.state,     64'(m_state));
            check("cyc_busy",      bus.busy,      (m_state != 0));
            check("cyc_underflow", bus.underflow, m_uf);
            check("cyc_strobe_cnt",    bus.strobe_cnt,    exp_s);
            check("cyc_underflow_cnt", bus.underflow_cnt, exp_u);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic count_strobes(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.fs_en === 1'b1) cnt++;
        end
    endtask

    task automatic load_rate(input logic [31:0] r);
        bus.rate_word = r;
        bus.cfg_load  = 1'b1;
        tick();
        bus.cfg_load  = 1'b0;
    endtask

    initial begin
        int cnt, lat, last_t, gap;
        bit found;
        logic [15:0] exp_ucnt;

        bus.enable = 1'b0; bus.rate_word = '0; bus.cfg_load = 1'b0;
        bus.fifo_level = '0; bus.fifo_empty = 1'b1; bus.clear_underflow = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        #1;
        check("reset_state", bus.state, 0);
        check("reset_busy",  bus.busy,  0);
        check("reset_fs_en", bus.fs_en, 0);
        check("reset_underflow", bus.underflow, 0);

        // Half rate: PRIME for one cycle, then RUN with fs_en every 2nd cycle.
        bus.rate_word = RATE_HALF; bus.cfg_load = 1'b1; bus.enable = 1'b1;
        bus.fifo_level = 6'd20; bus.fifo_empty = 1'b0;
        tick();
        bus.cfg_load = 1'b0;
        check("half_enter_prime", bus.state, 1);
        tick();
        check("half_enter_run", bus.state, 2);
        count_strobes(200, cnt);
        check("half_200cyc_strobes", cnt, 100);

        // Zero rate: RUN holds with no strobes.
        load_rate(32'h0);
        count_strobes(20, cnt);
        check("zero_rate_strobes", cnt, 0);
        check("zero_rate_state", bus.state, 2);

        // Maximum rate: at most one missed strobe in 20 cycles.
        load_rate(RATE_MAX);
        count_strobes(20, cnt);
        check("max_rate_strobes_ge19", (cnt >= 19 && cnt <= 20), 1);

        // Drain: 10 cycles of non-empty FIFO at half rate give 5 strobes, then IDLE.
        load_rate(RATE_HALF);
        repeat (3) tick();
        bus.enable = 1'b0;
        count_strobes(10, cnt);
        check("drain_state", bus.state, 3);
        check("drain_strobes", cnt, 5);
        bus.fifo_empty = 1'b1;
        tick();
        check("drain_to_idle", bus.state, 0);
        check("drain_no_underflow", bus.underflow, 0);
        check("drain_idle_busy", bus.busy, 0);

        // Priming below threshold, then the first strobe latency at quarter rate.
        load_rate(RATE_QUARTER);
        bus.fifo_empty = 1'b0; bus.fifo_level = 6'd10; bus.enable = 1'b1;
        count_strobes(50, cnt);
        check("prime_wait_state", bus.state, 1);
        check("prime_wait_strobes", cnt, 0);
        bus.fifo_level = 6'd16;
        lat = 0; found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            tick();
            if (bus.fs_en === 1'b1) begin found = 1'b1; lat = i; end
        end
        check("prime_first_strobe_latency", lat, 5);

        // Underflow in RUN at half rate: suppressed strobe, back to PRIME, sticky flag.
        load_rate(RATE_HALF);
        bus.fifo_empty = 1'b1; bus.fifo_level = 6'd0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (m_uf) found = 1'b1;
        end
        check("underflow_seen_in_bound", found, 1);
        check("underflow_flag", bus.underflow, 1);
        check("underflow_state_prime", bus.state, 1);
        check("underflow_no_strobe", bus.fs_en, 0);
`ifdef FS_EN_SCHEDULER_STATS_EN
        exp_ucnt = 16'd1;
`else
        exp_ucnt = 16'd0;
`endif
        check("underflow_cnt_one", bus.underflow_cnt, exp_ucnt);
        bus.clear_underflow = 1'b1;
        tick();
        bus.clear_underflow = 1'b0;
        check("underflow_cleared", bus.underflow, 0);

        // Clear held through a second underflow event: the set wins.
        bus.fifo_empty = 1'b0; bus.fifo_level = 6'd20;
        repeat (2) tick();
        bus.fifo_empty = 1'b1; bus.fifo_level = 6'd0; bus.clear_underflow = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (m_uf) found = 1'b1;
        end
        bus.clear_underflow = 1'b0;
        check("set_wins_seen", found, 1);
        check("set_wins_flag", bus.underflow, 1);
        bus.clear_underflow = 1'b1;
        tick();
        bus.clear_underflow = 1'b0;

        // Rate switch mid-RUN from half to quarter rate, then async reset mid-strobe.
        bus.fifo_empty = 1'b0; bus.fifo_level = 6'd20;
        repeat (6) tick();
        check("switch_in_run", bus.state, 2);
        load_rate(RATE_QUARTER);
        last_t = -1; gap = 0; cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.fs_en === 1'b1) begin
                if (last_t >= 0) gap = i - last_t;
                last_t = i;
                if (i >= 12) cnt++;
            end
        end
        check("switch_last_gap", gap, 4);
        check("switch_strobes_12cyc", cnt, 3);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            if (m_fs) found = 1'b1;
        end
        check("reset_point_is_strobe", bus.fs_en, 1);
        #1;
        rst_n = 1'b0;
        chk_on = 1'b0;
        #1;
        check("async_rst_fs_en", bus.fs_en, 0);
        check("async_rst_busy",  bus.busy,  0);
        check("async_rst_state", bus.state, 0);
        check("async_rst_underflow", bus.underflow, 0);
        check("async_rst_strobe_cnt", bus.strobe_cnt, 0);
        check("async_rst_underflow_cnt", bus.underflow_cnt, 0);
        model_reset();
        @(negedge sys_clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        tick();
        check("restart_prime", bus.state, 1);
        load_rate(RATE_HALF);
        count_strobes(20, cnt);
        check("restart_strobes", (cnt >= 8 && cnt <= 10), 1);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
